// File: rtl/mc_exec_core_if.sv
// Shared memory port of the multi-cycle MIPS core: one handshaked
// channel carries both instruction fetches and lw/sw data accesses.
interface mc_exec_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mc_exec_core.sv
// Multi-cycle MIPS-I subset core with a single shared memory port.
// Define MC_EXEC_OVF_TRAP_EN to trap on signed add/sub/addi overflow.
module mc_exec_core #(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    mc_exec_core_if.master bus,
    output logic [31:0] pc,
    output logic        halted,
`ifdef MC_EXEC_OVF_TRAP_EN
    output logic        trap,
`endif
    output logic [2:0]  state
);
    localparam int RW = $clog2(NREGS);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } st_t;

    st_t st, st_nxt;

    logic [31:0] ir, a, b, imm, alu_q, mdr;
    logic [31:0] rf [NREGS];
    logic [5:0]  op, fn;
    logic [RW-1:0] rs, rt, rd, wr_idx;

    logic is_add, is_sub, is_and, is_or, is_slt;
    logic is_addi, is_lw, is_sw, is_beq, is_j;
    logic is_r, legal;

    logic [31:0] opb, sum, dif, alu_y, daddr, npc;
    logic        xfer, issue, trap_hit;

    assign op     = ir[31:26];
    assign fn     = ir[5:0];
    assign rs     = ir[21 +: RW];
    assign rt     = ir[16 +: RW];
    assign rd     = ir[11 +: RW];
    assign wr_idx = is_r ? rd : rt;
    assign state  = st;
    assign halted = (st == S_HALT);
    assign xfer   = bus.mem_req && bus.mem_ack;

    always_comb begin
        is_add  = 1'b0;
        is_sub  = 1'b0;
        is_and  = 1'b0;
        is_or   = 1'b0;
        is_slt  = 1'b0;
        is_addi = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        unique case (1'b1)
            (op == 6'h00 && fn == 6'h20): is_add  = 1'b1;
            (op == 6'h00 && fn == 6'h22): is_sub  = 1'b1;
            (op == 6'h00 && fn == 6'h24): is_and  = 1'b1;
            (op == 6'h00 && fn == 6'h25): is_or   = 1'b1;
            (op == 6'h00 && fn == 6'h2A): is_slt  = 1'b1;
            (op == 6'h08):                is_addi = 1'b1;
            (op == 6'h23):                is_lw   = 1'b1;
            (op == 6'h2B):                is_sw   = 1'b1;
            (op == 6'h04):                is_beq  = 1'b1;
            (op == 6'h02):                is_j    = 1'b1;
            default: ;
        endcase
        is_r  = is_add | is_sub | is_and | is_or | is_slt;
        legal = is_r | is_addi | is_lw | is_sw | is_beq | is_j;
    end

    always_comb begin
        opb   = is_r ? b : imm;
        sum   = a + opb;
        dif   = a - b;
        daddr = {sum[31:2], 2'b00};
        alu_y = sum;
        unique case (1'b1)
            is_sub:  alu_y = dif;
            is_and:  alu_y = a & b;
            is_or:   alu_y = a | b;
            is_slt:  alu_y = {31'd0, $signed(a) < $signed(b)};
            default: ;
        endcase
    end

`ifdef MC_EXEC_OVF_TRAP_EN
    always_comb begin
        trap_hit = 1'b0;
        if ((is_add || is_addi) && a[31] == opb[31] && sum[31] != a[31])
            trap_hit = 1'b1;
        if (is_sub && a[31] != b[31] && dif[31] != a[31])
            trap_hit = 1'b1;
    end
`else
    assign trap_hit = 1'b0;
`endif

    // pc already holds the incremented value once EXEC is reached
    always_comb begin
        npc = pc;
        if (st == S_EXEC) begin
            if (is_beq && a == b)
                npc = pc + {imm[29:0], 2'b00};
            else if (is_j)
                npc = {pc[31:28], ir[25:0], 2'b00};
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            S_FETCH:  if (xfer) st_nxt = S_DECODE;
            S_DECODE: st_nxt = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (trap_hit)               st_nxt = S_HALT;
                else if (is_lw || is_sw)    st_nxt = S_MEM;
                else if (is_r || is_addi)   st_nxt = S_WB;
                else                        st_nxt = S_FETCH;
            end
            S_MEM:    if (xfer) st_nxt = is_lw ? S_WB : S_FETCH;
            S_WB:     st_nxt = S_FETCH;
            default:  st_nxt = S_HALT;
        endcase
    end

    // a new request starts on every edge entering FETCH or MEM,
    // plus the idle FETCH cycle right after reset
    assign issue = (st_nxt == S_FETCH && (st != S_FETCH || !bus.mem_req))
                || (st_nxt == S_MEM && st != S_MEM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_FETCH;
        else        st <= st_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            pc    <= RESET_PC;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            imm   <= '0;
            alu_q <= '0;
            mdr   <= '0;
`ifdef MC_EXEC_OVF_TRAP_EN
            trap  <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (issue) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= (st_nxt == S_MEM) && is_sw;
                bus.mem_addr <= (st_nxt == S_MEM) ? daddr : npc;
                if (st_nxt == S_MEM) bus.mem_wdata <= b;
            end else if (xfer) begin
                bus.mem_req <= 1'b0;
                bus.mem_we  <= 1'b0;
            end
            case (st)
                S_FETCH: if (xfer) begin
                    ir <= bus.mem_rdata;
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a   <= rf[rs];
                    b   <= rf[rt];
                    imm <= {{16{ir[15]}}, ir[15:0]};
                end
                S_EXEC: begin
                    alu_q <= alu_y;
                    pc    <= npc;
`ifdef MC_EXEC_OVF_TRAP_EN
                    if (trap_hit) trap <= 1'b1;
`endif
                end
                S_MEM: if (xfer && is_lw) mdr <= bus.mem_rdata;
                S_WB: if (wr_idx != '0)
                    rf[wr_idx] <= is_lw ? mdr : alu_q;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_exec_core.sv
// Bench for mc_exec_core: random and directed programs checked against
// an instruction-level reference model of the ISA, bus trace and timing.
module tb_mc_exec_core;
    localparam logic [31:0] RPC = 32'h40;
`ifdef MC_EXEC_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic        halted;
    logic [2:0]  dbg_state;
`ifdef MC_EXEC_OVF_TRAP_EN
    logic        trap;
`endif

    mc_exec_core_if bus ();

    mc_exec_core #(.NREGS(32), .RESET_PC(RPC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc     (pc),
        .halted (halted),
`ifdef MC_EXEC_OVF_TRAP_EN
        .trap   (trap),
`endif
        .state  (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    logic [31:0] mem [int unsigned];
    logic [31:0] mm  [int unsigned];
    xact_t obs_q[$];
    xact_t exp_q[$];
    int wait_n = 0;
    int exp_cyc;
    logic [31:0] exp_pc;
    bit exp_trap, exp_halt;

    function automatic logic [31:0] tb_rd(input logic [31:0] ad);
        return mem.exists(ad[31:2]) ? mem[ad[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] mm_rd(input logic [31:0] ad);
        return mm.exists(ad[31:2]) ? mm[ad[31:2]] : 32'h0;
    endfunction

    task automatic put(input logic [31:0] ad, input logic [31:0] v);
        mem[ad[31:2]] = v;
        mm[ad[31:2]]  = v;
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] f,
        input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] o,
        input logic [4:0] t, input logic [4:0] s, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    // memory model: fixed wait states, random ack noise while idle
    bit          busy = 1'b0;
    int          cnt = 0;
    logic        l_we;
    logic [31:0] l_addr, l_wd;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (!rst_n || !bus.mem_req) begin
            busy = 1'b0;
            cnt = 0;
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
        end else begin
            if (!busy) begin
                busy   = 1'b1;
                cnt    = 0;
                l_we   = bus.mem_we;
                l_addr = bus.mem_addr;
                l_wd   = bus.mem_wdata;
            end else begin
                chk("hold_addr", bus.mem_addr, l_addr);
                chk("hold_we", bus.mem_we, l_we);
                chk("hold_wdata", bus.mem_wdata, l_wd);
            end
            if (cnt >= wait_n) begin
                bus.mem_ack = 1'b1;
                busy = 1'b0;
                if (l_we) begin
                    mem[l_addr[31:2]] = l_wd;
                    bus.mem_rdata = $urandom;
                    obs_q.push_back('{1'b1, l_addr, l_wd});
                end else begin
                    bus.mem_rdata = tb_rd(l_addr);
                    obs_q.push_back('{1'b0, l_addr, 32'h0});
                end
            end else begin
                cnt++;
                bus.mem_ack = 1'b0;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // instruction-level reference: ISA semantics plus per-class cycle cost
    task automatic model_run(input int max_ins, input int w);
        logic [31:0] r [32];
        logic [31:0] p, ins, x, y, sx, res, ad;
        logic [5:0]  o, f;
        logic [4:0]  s, t, d;
        longint      wide;
        longint      lim;
        bit          ovf;
        lim = 64'sd2147483647;
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        p = RPC;
        exp_q.delete();
        exp_cyc = 0;
        exp_trap = 1'b0;
        exp_halt = 1'b0;
        for (int n = 0; n < max_ins; n++) begin
            ins = mm_rd(p);
            exp_q.push_back('{1'b0, p, 32'h0});
            p = p + 4;
            o = ins[31:26]; f = ins[5:0];
            s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
            sx = {{16{ins[15]}}, ins[15:0]};
            x = r[s]; y = r[t];
            ovf = 1'b0;
            if (o == 6'h00 && f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}
                || o == 6'h08) begin
                res = 32'h0;
                wide = 0;
                if (o == 6'h08) begin
                    wide = longint'($signed(x)) + longint'($signed(sx));
                    res = x + sx;
                    ovf = 1'b1;
                end else case (f)
                    6'h20: begin
                        wide = longint'($signed(x)) + longint'($signed(y));
                        res = x + y; ovf = 1'b1;
                    end
                    6'h22: begin
                        wide = longint'($signed(x)) - longint'($signed(y));
                        res = x - y; ovf = 1'b1;
                    end
                    6'h24: res = x & y;
                    6'h25: res = x | y;
                    default: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                endcase
                ovf = ovf && (wide > lim || wide < -lim - 1);
                if (TRAP_EN && ovf) begin
                    exp_cyc += 3 + w;
                    exp_trap = 1'b1;
                    exp_halt = 1'b1;
                    break;
                end
                if (o == 6'h08) begin
                    if (t != 0) r[t] = res;
                end else if (d != 0) r[d] = res;
                exp_cyc += 4 + w;
            end else if (o == 6'h23 || o == 6'h2B) begin
                ad = (x + sx) & 32'hFFFF_FFFC;
                if (o == 6'h23) begin
                    exp_q.push_back('{1'b0, ad, 32'h0});
                    if (t != 0) r[t] = mm_rd(ad);
                    exp_cyc += 5 + 2 * w;
                end else begin
                    exp_q.push_back('{1'b1, ad, y});
                    mm[ad[31:2]] = y;
                    exp_cyc += 4 + 2 * w;
                end
            end else if (o == 6'h04) begin
                if (x == y) p = p + (sx << 2);
                exp_cyc += 3 + w;
            end else if (o == 6'h02) begin
                p = {p[31:28], ins[25:0], 2'b00};
                exp_cyc += 3 + w;
            end else begin
                exp_cyc += 2 + w;
                exp_halt = 1'b1;
                break;
            end
        end
        exp_pc = p;
    endtask

    task automatic run_prog(input int max_ins, input int w, input bit loops);
        int  cyc;
        bit  done;
        bit  any_req;
        int  n;
        int  b0;
        wait_n = w;
        model_run(max_ins, w);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_pc", pc, RPC);
        chk("rst_state", dbg_state, 3'd0);
        chk("rst_halted", halted, 1'b0);
`ifdef MC_EXEC_OVF_TRAP_EN
        chk("rst_trap", trap, 1'b0);
`endif
        @(negedge clk);
        obs_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_req", bus.mem_req, 1'b1);
        chk("first_addr", bus.mem_addr, RPC);
        chk("first_we", bus.mem_we, 1'b0);
        cyc = 0;
        done = 1'b0;
        while (cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (halted || (loops && obs_q.size() >= exp_q.size())) begin
                done = 1'b1;
                break;
            end
        end
        chk("finished", done, 1'b1);
        if (!loops) begin
            chk("cycles", cyc, exp_cyc);
            chk("pc_end", pc, exp_pc);
            chk("halted", halted, exp_halt);
`ifdef MC_EXEC_OVF_TRAP_EN
            chk("trap", trap, exp_trap);
`endif
            any_req = 1'b0;
            repeat (4) begin
                @(posedge clk);
                #1;
                if (bus.mem_req) any_req = 1'b1;
            end
            chk("req_after_halt", any_req, 1'b0);
            chk("ntrans", obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            b0 = bad;
            chk("xact_addr", {obs_q[i].we, obs_q[i].addr},
                {exp_q[i].we, exp_q[i].addr});
            chk("xact_data", obs_q[i].data, exp_q[i].data);
            if (bad != b0) break;
        end
    endtask

    function automatic bit saw_write(input logic [31:0] ad,
                                     input logic [31:0] v);
        foreach (obs_q[i])
            if (obs_q[i].we && obs_q[i].addr == ad && obs_q[i].data == v)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_basic();
        mem.delete(); mm.delete();
        put(RPC + 0,  enc_i(6'h08, 5'd1, 5'd0, 16'd5));
        put(RPC + 4,  enc_i(6'h08, 5'd2, 5'd0, 16'd7));
        put(RPC + 8,  enc_r(6'h20, 5'd3, 5'd1, 5'd2));
        put(RPC + 12, enc_i(6'h2B, 5'd3, 5'd0, 16'd0));
        put(RPC + 16, enc_i(6'h23, 5'd4, 5'd0, 16'd0));
        put(RPC + 20, enc_i(6'h2B, 5'd4, 5'd0, 16'd4));
        put(RPC + 24, 32'hFC00_0000);
    endtask

    task automatic load_random();
        logic [5:0] fns [5];
        logic [31:0] ad;
        int k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        mem.delete(); mm.delete();
        for (int i = 0; i < 16; i++) put(32'h200 + 4 * i, $urandom);
        k = $urandom_range(8, 20);
        ad = RPC;
        for (int i = 0; i < k; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: put(ad, enc_i(6'h08, 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 16'($urandom)));
                3, 4, 5: put(ad, enc_r(fns[$urandom_range(0, 4)],
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7))));
                6, 9: put(ad, enc_i(6'h23, 5'($urandom_range(0, 7)), 5'd0,
                    16'(32'h200 + 4 * $urandom_range(0, 15)
                        + $urandom_range(0, 3))));
                7: put(ad, enc_i(6'h2B, 5'($urandom_range(0, 7)), 5'd0,
                    16'(32'h200 + 4 * $urandom_range(0, 15)
                        + $urandom_range(0, 3))));
                default: put(ad, enc_i(6'h04, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 16'($urandom_range(0, 2))));
            endcase
            ad = ad + 4;
        end
        for (int i = 0; i < 3; i++) begin
            case ($urandom_range(0, 2))
                0: put(ad, 32'hFC00_0000);
                1: put(ad, enc_r(6'h21, 5'd1, 5'd2, 5'd3));
                default: put(ad, 32'h0);
            endcase
            ad = ad + 4;
        end
    endtask

    initial begin
        logic [31:0] ad;

        load_basic();
        run_prog(100, 0, 1'b0);
        chk("basic_sw12_w0", saw_write(32'h0, 32'd12), 1'b1);
        chk("basic_r4_w0", saw_write(32'h4, 32'd12), 1'b1);
        load_basic();
        run_prog(100, 3, 1'b0);
        chk("basic_sw12_w3", saw_write(32'h0, 32'd12), 1'b1);

        mem.delete(); mm.delete();
        put(RPC, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
        run_prog(4, 1, 1'b1);

        mem.delete(); mm.delete();
        put(RPC, {6'h02, 26'h100});
        put(32'h400, 32'hFC00_0000);
        run_prog(100, 0, 1'b0);
        chk("jump_pc", pc, 32'h404);

        mem.delete(); mm.delete();
        ad = RPC;
        put(ad, enc_i(6'h08, 5'd1, 5'd0, 16'd1)); ad += 4;
        for (int i = 0; i < 30; i++) begin
            put(ad, enc_r(6'h20, 5'd1, 5'd1, 5'd1)); ad += 4;
        end
        put(ad, enc_i(6'h08, 5'd2, 5'd1, 16'hFFFF)); ad += 4;
        put(ad, enc_r(6'h20, 5'd3, 5'd1, 5'd2)); ad += 4;
        put(ad, enc_i(6'h08, 5'd5, 5'd0, 16'd1)); ad += 4;
        put(ad, enc_r(6'h20, 5'd4, 5'd3, 5'd5)); ad += 4;
        put(ad, enc_i(6'h2B, 5'd4, 5'd0, 16'h0200)); ad += 4;
        put(ad, 32'hFC00_0000);
        run_prog(100, 1, 1'b0);
        chk("ovf_store", saw_write(32'h200, 32'h8000_0000), !TRAP_EN);

        // reset pulled while a wait-stated fetch is outstanding
        load_basic();
        wait_n = 3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", bus.mem_req, 1'b0);
        run_prog(100, 2, 1'b0);

        for (int it = 0; it < 25; it++) begin
            load_random();
            run_prog(200, $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
